// File: rtl/bk16_stream_accum_if.sv
// Stream-side and adder-side signal bundle for bk16_stream_accum.
// The accumulator is the slave; the sample source, result sink and external bk16 form the master side.
interface bk16_stream_accum_if #(
  parameter int HI_W    = 16,
  parameter int COUNT_W = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [15:0]         in_data;
  logic                in_last;
  logic                clr;
  logic [15:0]         add_a;
  logic [15:0]         add_b;
  logic [15:0]         add_sum;
  logic                add_cout;
  logic                out_valid;
  logic                out_ready;
  logic [HI_W+15:0]    out_sum;
  logic [COUNT_W-1:0]  out_count;
  logic                out_ovf;

  modport slave (
    input  in_valid, in_data, in_last, clr, add_sum, add_cout, out_ready,
    output in_ready, add_a, add_b, out_valid, out_sum, out_count, out_ovf
  );

  modport master (
    output in_valid, in_data, in_last, clr, add_sum, add_cout, out_ready,
    input  in_ready, add_a, add_b, out_valid, out_sum, out_count, out_ovf
  );
endinterface

// File: rtl/bk16_stream_accum.sv
// Framed streaming accumulator driving an external 16-bit bk16 adder; emits {hi, lo} per frame.
// Optional macro BK16_ACC_ADD_PIPE_EN registers the adder result and adds an ACC_WAIT state.
module bk16_stream_accum #(
  parameter int HI_W    = 16,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  bk16_stream_accum_if.slave bus
);

`ifdef BK16_ACC_ADD_PIPE_EN
  typedef enum logic [1:0] {ACC = 2'd0, ACC_WAIT = 2'd1, HOLD = 2'd2} state_t;
`else
  typedef enum logic [1:0] {ACC = 2'd0, HOLD = 2'd2} state_t;
`endif

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_t              r_state;
  state_t              w_state_next;
  logic [15:0]         r_acc_lo;
  logic [HI_W-1:0]     r_acc_hi;
  logic [COUNT_W-1:0]  r_count;
  logic                r_ovf;
  logic                r_out_valid;
  logic [HI_W+15:0]    r_out_sum;
  logic [COUNT_W-1:0]  r_out_count;
  logic                r_out_ovf;

  logic                w_accept;
  logic                w_clr_eff;
  logic                w_clr_only;
  logic                w_upd_en;
  logic [15:0]         w_upd_sum;
  logic                w_upd_cout;
  logic                w_upd_clr;
  logic                w_upd_last;
  logic [HI_W-1:0]     w_base_hi;
  logic [HI_W-1:0]     w_new_hi;
  logic [COUNT_W-1:0]  w_base_cnt;
  logic [COUNT_W-1:0]  w_new_cnt;
  logic                w_new_ovf;
  logic [15:0]         w_add_a;
  logic [15:0]         w_add_b;

  assign w_accept = (r_state == ACC) && bus.in_valid;

`ifdef BK16_ACC_ADD_PIPE_EN
  logic [15:0] r_p_sum;
  logic        r_p_cout;
  logic        r_p_clr;
  logic        r_p_last;
  logic        r_clr_pend;

  // A clr seen while waiting on the registered sum is replayed in the next ACC cycle.
  assign w_clr_eff = bus.clr | r_clr_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p_sum    <= '0;
      r_p_cout   <= 1'b0;
      r_p_clr    <= 1'b0;
      r_p_last   <= 1'b0;
      r_clr_pend <= 1'b0;
    end else begin
      if (w_accept) begin
        r_p_sum  <= bus.add_sum;
        r_p_cout <= bus.add_cout;
        r_p_clr  <= w_clr_eff;
        r_p_last <= bus.in_last;
      end
      if (r_state == ACC)
        r_clr_pend <= 1'b0;
      else if (r_state == ACC_WAIT)
        r_clr_pend <= bus.clr & ~r_p_last;
    end
  end

  assign w_upd_en   = (r_state == ACC_WAIT);
  assign w_upd_sum  = r_p_sum;
  assign w_upd_cout = r_p_cout;
  assign w_upd_clr  = r_p_clr;
  assign w_upd_last = r_p_last;
`else
  assign w_clr_eff  = bus.clr;
  assign w_upd_en   = w_accept;
  assign w_upd_sum  = bus.add_sum;
  assign w_upd_cout = bus.add_cout;
  assign w_upd_clr  = bus.clr;
  assign w_upd_last = bus.in_last;
`endif

  assign w_clr_only = (r_state == ACC) && w_clr_eff && !w_accept;

  assign w_base_hi  = w_upd_clr ? '0 : r_acc_hi;
  assign w_new_hi   = w_base_hi + HI_W'(w_upd_cout);
  assign w_base_cnt = w_upd_clr ? '0 : r_count;
  assign w_new_cnt  = (w_base_cnt == CNT_MAX) ? CNT_MAX : w_base_cnt + COUNT_W'(1);
  assign w_new_ovf  = (r_ovf & ~w_upd_clr) | ((&w_base_hi) & w_upd_cout);

  always_comb begin
    w_state_next = r_state;
    w_add_a      = r_acc_lo;
    w_add_b      = '0;
    case (r_state)
      ACC: begin
        w_add_a = w_clr_eff ? '0 : r_acc_lo;
        w_add_b = bus.in_valid ? bus.in_data : '0;
`ifdef BK16_ACC_ADD_PIPE_EN
        if (w_accept)
          w_state_next = ACC_WAIT;
`else
        if (w_accept && bus.in_last)
          w_state_next = HOLD;
`endif
      end
`ifdef BK16_ACC_ADD_PIPE_EN
      ACC_WAIT: w_state_next = r_p_last ? HOLD : ACC;
`endif
      HOLD: begin
        if (bus.out_ready)
          w_state_next = ACC;
      end
      default: w_state_next = ACC;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= ACC;
    else
      r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc_lo    <= '0;
      r_acc_hi    <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_upd_en) begin
      r_acc_lo <= w_upd_sum;
      r_acc_hi <= w_new_hi;
      r_count  <= w_new_cnt;
      r_ovf    <= w_new_ovf;
      if (w_upd_last) begin
        r_out_sum   <= {w_new_hi, w_upd_sum};
        r_out_count <= w_new_cnt;
        r_out_ovf   <= w_new_ovf;
        r_out_valid <= 1'b1;
      end
    end else if (w_clr_only) begin
      r_acc_lo <= '0;
      r_acc_hi <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else if ((r_state == HOLD) && bus.out_ready) begin
      // Result stays on out_sum after the handshake; only valid drops.
      r_out_valid <= 1'b0;
      r_acc_lo    <= '0;
      r_acc_hi    <= '0;
      r_count     <= '0;
      r_ovf       <= 1'b0;
    end
  end

  assign bus.in_ready  = (r_state == ACC);
  assign bus.add_a     = w_add_a;
  assign bus.add_b     = w_add_b;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_count = r_out_count;
  assign bus.out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_bk16_stream_accum.sv
// Scoreboard bench for bk16_stream_accum: two instances (HI_W=16/COUNT_W=8 and HI_W=1/COUNT_W=3)
// share one stimulus stream; a frame-level sum model predicts results for both.
module tb_bk16_stream_accum;

`ifdef BK16_ACC_ADD_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        d_in_valid = 1'b0;
  logic [15:0] d_in_data = '0;
  logic        d_in_last = 1'b0;
  logic        d_clr = 1'b0;
  logic        d_out_ready = 1'b1;

  always #5 clk = ~clk;

  bk16_stream_accum_if #(.HI_W(16), .COUNT_W(8)) if0 ();
  bk16_stream_accum_if #(.HI_W(1),  .COUNT_W(3)) if1 ();

  assign if0.in_valid = d_in_valid;  assign if1.in_valid = d_in_valid;
  assign if0.in_data  = d_in_data;   assign if1.in_data  = d_in_data;
  assign if0.in_last  = d_in_last;   assign if1.in_last  = d_in_last;
  assign if0.clr      = d_clr;       assign if1.clr      = d_clr;
  assign if0.out_ready = d_out_ready; assign if1.out_ready = d_out_ready;
  // Behavioural stand-in for the external bk16 adder.
  assign {if0.add_cout, if0.add_sum} = {1'b0, if0.add_a} + {1'b0, if0.add_b};
  assign {if1.add_cout, if1.add_sum} = {1'b0, if1.add_a} + {1'b0, if1.add_b};

  bk16_stream_accum #(.HI_W(16), .COUNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  bk16_stream_accum #(.HI_W(1),  .COUNT_W(3)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  typedef struct {
    logic [31:0] s0; logic [7:0] c0; logic o0;
    logic [16:0] s1; logic [2:0] c1; logic o1;
  } exp_t;

  exp_t    q[$];
  int      n_cmp = 0;
  int      n_err = 0;
  int      cyc = 0;
  int      last_acc_cyc = 0;
  int      frames_pushed = 0;
  int      frames_done = 0;
  longint  m_sum = 0;
  int      m_beats = 0;
  bit      frame_open = 1'b1;
  bit      prev_acc = 1'b0;
  bit      prev_last = 1'b0;
  bit      prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Reference: total since last clear, unbounded; each instance sees it truncated to its width.
  function automatic exp_t make_exp(input longint s, input int beats);
    exp_t e;
    longint t = s;
    e.s0 = t[31:0];
    e.o0 = (s >= 64'h1_0000_0000);
    e.c0 = (beats > 255) ? 8'd255 : beats[7:0];
    e.s1 = t[16:0];
    e.o1 = (s >= 64'h2_0000);
    e.c1 = (beats > 7) ? 3'd7 : beats[2:0];
    return e;
  endfunction

  // Stimulus-side tracker: applies each cycle's clr/accept to the model and pushes expected results.
  always @(negedge clk) begin
    if (rst) begin
      m_sum = 0; m_beats = 0; frame_open = 1'b1; prev_acc = 1'b0; prev_last = 1'b0;
    end else begin
      if (prev_acc)
        chk("in_ready_after_accept", if0.in_ready, (!prev_last && LAT == 1));
      if (if0.clr && frame_open) begin
        m_sum = 0; m_beats = 0;
      end
      prev_acc = if0.in_valid && if0.in_ready;
      prev_last = if0.in_last;
      if (prev_acc) begin
        logic [15:0] lo;
        logic [16:0] full;
        lo = m_sum[15:0];
        full = {1'b0, lo} + {1'b0, if0.in_data};
        chk("add_a", if0.add_a, lo);
        chk("add_b", if0.add_b, if0.in_data);
        chk("add_cout", if0.add_cout, full[16]);
        chk("add_a_hi1", if1.add_a, lo);
        m_sum = m_sum + longint'(if0.in_data);
        m_beats++;
        if (if0.in_last) begin
          q.push_back(make_exp(m_sum, m_beats));
          frames_pushed++;
          last_acc_cyc = cyc;
          m_sum = 0; m_beats = 0; frame_open = 1'b0;
        end
      end
      if (if0.out_valid && if0.out_ready)
        frame_open = 1'b1;
    end
  end

  // Monitor: compares presented results against the queue head, pops on handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      chk("out_valid_match", if1.out_valid, if0.out_valid);
      if (if0.out_valid) begin
        chk("in_ready_in_hold", if0.in_ready, 1'b0);
        if (q.size() == 0) begin
          timeout("unexpected_out_valid");
        end else begin
          exp_t e;
          e = q[0];
          chk("out_sum_w16", if0.out_sum, e.s0);
          chk("out_count_w16", if0.out_count, e.c0);
          chk("out_ovf_w16", if0.out_ovf, e.o0);
          chk("out_sum_w1", if1.out_sum, e.s1);
          chk("out_count_w1", if1.out_count, e.c1);
          chk("out_ovf_w1", if1.out_ovf, e.o1);
          if (!prev_ov)
            chk("latency", cyc - last_acc_cyc, LAT);
          if (if0.out_ready) begin
            $display("frame %0d: sum=0x%08h count=%0d ovf=%0d | w1 sum=0x%05h count=%0d ovf=%0d",
                     frames_done, if0.out_sum, if0.out_count, if0.out_ovf,
                     if1.out_sum, if1.out_count, if1.out_ovf);
            void'(q.pop_front());
            frames_done++;
          end
        end
      end
      prev_ov = if0.out_valid;
    end
  end

  task automatic send_beat(input logic [15:0] d, input bit last, input bit c);
    int n = 0;
    d_in_valid = 1'b1; d_in_data = d; d_in_last = last; d_clr = c;
    @(negedge clk);
    while (!if0.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) timeout("send_beat");
    @(posedge clk); #1;
    d_in_valid = 1'b0; d_in_last = 1'b0; d_clr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || if0.out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("wait_idle");
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] pick_data();
    case ($urandom % 4)
      0: return 16'hFFFF;
      1: return 16'($urandom);
      2: return 16'($urandom % 16);
      default: return 16'hFF00 | 16'($urandom % 256);
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", if0.out_valid, 1'b0);
    chk("rst_out_sum", if0.out_sum, 32'h0);
    chk("rst_out_count", if0.out_count, 8'h0);
    chk("rst_out_ovf", if0.out_ovf, 1'b0);
    chk("rst_in_ready", if0.in_ready, 1'b1);
    chk("rst_out_sum_w1", if1.out_sum, 17'h0);
    rst = 1'b0;

    send_beat(16'h0001, 0, 0); send_beat(16'h0002, 0, 0); send_beat(16'h0003, 1, 0);
    wait_idle();
    send_beat(16'hFFFF, 0, 0); send_beat(16'h0001, 1, 0);
    wait_idle();
    repeat (3) send_beat(16'hFFFF, 0, 0);
    send_beat(16'hFFFF, 1, 0);
    wait_idle();

    d_out_ready = 1'b0;
    send_beat(16'h0010, 1, 0);
    begin
      int n = 0;
      while (!if0.out_valid && n < 10) begin @(negedge clk); n++; end
      if (n >= 10) timeout("hold_wait");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", if0.out_valid, 1'b1);
      chk("hold_out_sum", if0.out_sum, 32'h10);
      chk("hold_in_ready", if0.in_ready, 1'b0);
    end
    @(posedge clk); #1;
    d_out_ready = 1'b1;
    wait_idle();
    send_beat(16'h0007, 1, 0);
    wait_idle();

    send_beat(16'h1234, 0, 0); send_beat(16'h0005, 1, 1);
    wait_idle();
    for (int i = 0; i < 9; i++) send_beat(16'h0100, i == 8, 0);
    wait_idle();

    send_beat(16'h0001, 0, 0); send_beat(16'h0002, 0, 0);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", if0.out_valid, 1'b0);
    chk("midrst_add_a", if0.add_a, 16'h0);
    chk("midrst_in_ready", if0.in_ready, 1'b1);
    chk("midrst_out_count", if0.out_count, 8'h0);
    chk("midrst_add_a_w1", if1.add_a, 16'h0);
    q.delete();
    @(negedge clk); @(posedge clk); #2;
    rst = 1'b0;
    send_beat(16'h0009, 1, 0);
    wait_idle();

    for (int i = 0; i < 1500; i++) begin
      d_in_valid  = ($urandom % 10) < 7;
      d_in_data   = pick_data();
      d_in_last   = ($urandom % 6) == 0;
      d_clr       = ($urandom % 25) == 0;
      d_out_ready = ($urandom % 10) < 7;
      @(posedge clk); #1;
    end
    d_in_valid = 1'b0; d_in_last = 1'b0; d_clr = 1'b0; d_out_ready = 1'b1;
    wait_idle();
    chk("frames_done", frames_done, frames_pushed);
    chk("queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
